// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared constants and types for the 8-point DCT frame sequencer.
//   N_PTS        points per frame
//   IDX_W        width of a coefficient / sample index
//   DEF_DIN_W    default sample width (signed)
//   DEF_DOUT_W   default coefficient width (signed)
//   dct_state_t  core FSM states
//   sample_t     default-width signed sample
//   coef_t       default-width signed coefficient
// -----------------------------------------------------------------------------
package dct_pkg;

    localparam int N_PTS      = 8;
    localparam int IDX_W      = 3;
    localparam int DEF_DIN_W  = 8;
    localparam int DEF_DOUT_W = 19;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } dct_state_t;

    typedef logic signed [DEF_DIN_W-1:0]  sample_t;
    typedef logic signed [DEF_DOUT_W-1:0] coef_t;

endpackage

// File: rtl/dct_sample_buf.sv
// -----------------------------------------------------------------------------
// dct_sample_buf
// Collects serial samples into an N_PTS-entry frame buffer.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     sample valid
//   in_data      sample value
//   clear        empties the buffer (frame handed to the core)
//   in_ready     high while fewer than N_PTS samples are held
//   full         registered frame-complete flag (lags the counter by one cycle)
//   frame        buffered frame, sample k at [k*DIN_W +: DIN_W]
// -----------------------------------------------------------------------------
module dct_sample_buf
    import dct_pkg::*;
#(
    parameter int DIN_W = DEF_DIN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DIN_W-1:0]       in_data,
    input  logic                   clear,
    output logic                   in_ready,
    output logic                   full,
    output logic [N_PTS*DIN_W-1:0] frame
);

    localparam int CNT_W = $clog2(N_PTS + 1);

    logic [CNT_W-1:0]       fill_cnt_r;
    logic [N_PTS*DIN_W-1:0] buf_r;
    logic                   full_r;
    logic                   take_s;

    assign in_ready = (fill_cnt_r < CNT_W'(N_PTS));
    assign take_s   = in_valid & in_ready;
    assign full     = full_r;
    assign frame    = buf_r;

    // Fill counter and sample storage; clear only ever arrives while the
    // buffer is full, so it can never collide with an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r <= '0;
            buf_r      <= '0;
        end else if (clear) begin
            fill_cnt_r <= '0;
        end else if (take_s) begin
            buf_r[fill_cnt_r[IDX_W-1:0]*DIN_W +: DIN_W] <= in_data;
            fill_cnt_r <= fill_cnt_r + CNT_W'(1);
        end
    end

    // Registered full flag keeps the launch decision off the input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else begin
            full_r <= (fill_cnt_r == CNT_W'(N_PTS));
        end
    end

endmodule

// File: rtl/dct_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dct_frame_ctrl
// Sequencer for the 8-point DCT array: frames serial samples, launches the
// DCT, waits DCT_LAT cycles, captures the coefficients and streams them out
// with valid/ready backpressure.
// Optional build macro: DCT_CTRL_THRESH_EN -- zero captured coefficients
// whose magnitude is below thresh. Undefined: thresh is ignored.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data/in_ready   serial sample input
//   dct_in, dct_en, dct_cs      frame and controls toward the DCT
//   dct_z                 DCT result, Zk at [k*DOUT_W +: DOUT_W]
//   thresh                zeroing threshold (unsigned)
//   out_valid/out_data/out_idx/out_last/out_ready   coefficient stream
//   busy                  core FSM not idle
//   frame_cnt             completed frames, wraps
// -----------------------------------------------------------------------------
module dct_frame_ctrl
    import dct_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int DCT_LAT = 2,
    parameter int FCNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DIN_W-1:0]        in_data,
    output logic                    in_ready,
    output logic [N_PTS*DIN_W-1:0]  dct_in,
    output logic                    dct_en,
    output logic                    dct_cs,
    input  logic [N_PTS*DOUT_W-1:0] dct_z,
    input  logic [DOUT_W-2:0]       thresh,
    output logic                    out_valid,
    output logic [DOUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [FCNT_W-1:0]       frame_cnt
);

    localparam int WCNT_W = (DCT_LAT > 0) ? $clog2(DCT_LAT + 1) : 1;

    dct_state_t               state_r;
    logic [WCNT_W-1:0]        wcnt_r;
    logic [IDX_W-1:0]         idx_r;
    logic [DOUT_W-1:0]        coef_r [N_PTS];
    logic [DOUT_W-1:0]        cap_s  [N_PTS];
    logic [N_PTS*DIN_W-1:0]   frame_s;
    logic                     full_s;
    logic                     clear_s;

    logic [N_PTS*DIN_W-1:0]   dct_in_r;
    logic                     dct_en_r;
    logic                     dct_cs_r;
    logic                     out_valid_r;
    logic [DOUT_W-1:0]        out_data_r;
    logic [IDX_W-1:0]         out_idx_r;
    logic                     out_last_r;
    logic                     busy_r;
    logic [FCNT_W-1:0]        frame_cnt_r;

`ifdef DCT_CTRL_THRESH_EN
    // Magnitude is taken one bit wider so the most negative code cannot wrap.
    function automatic logic [DOUT_W-1:0] thresh_zero(input logic [DOUT_W-1:0] z,
                                                      input logic [DOUT_W-2:0] th);
        logic [DOUT_W:0] ext;
        logic [DOUT_W:0] mag;
        ext = {z[DOUT_W-1], z};
        if (z[DOUT_W-1]) begin
            mag = (~ext) + {{DOUT_W{1'b0}}, 1'b1};
        end else begin
            mag = ext;
        end
        if (mag < {2'b00, th}) begin
            thresh_zero = '0;
        end else begin
            thresh_zero = z;
        end
    endfunction
`else
    logic thresh_unused_s;
    assign thresh_unused_s = ^thresh;
`endif

    dct_sample_buf #(
        .DIN_W    (DIN_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clear    (clear_s),
        .in_ready (in_ready),
        .full     (full_s),
        .frame    (frame_s)
    );

    // The buffer is emptied on the same edge the frame is handed to the DCT.
    assign clear_s = (state_r == S_IDLE) && full_s;

    // Coefficient values as they will be captured (optionally thresholded).
    always_comb begin
        for (int k = 0; k < N_PTS; k++) begin
`ifdef DCT_CTRL_THRESH_EN
            cap_s[k] = thresh_zero(dct_z[k*DOUT_W +: DOUT_W], thresh);
`else
            cap_s[k] = dct_z[k*DOUT_W +: DOUT_W];
`endif
        end
    end

    // Core FSM: launch, fixed-latency wait, capture, serial drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            wcnt_r      <= '0;
            idx_r       <= '0;
            dct_in_r    <= '0;
            dct_en_r    <= 1'b0;
            dct_cs_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= '0;
            for (int k = 0; k < N_PTS; k++) begin
                coef_r[k] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (full_s) begin
                        dct_in_r <= frame_s;
                        dct_en_r <= 1'b1;
                        dct_cs_r <= 1'b1;
                        wcnt_r   <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    dct_en_r <= 1'b0;
                    if (wcnt_r == WCNT_W'(DCT_LAT)) begin
                        for (int k = 0; k < N_PTS; k++) begin
                            coef_r[k] <= cap_s[k];
                        end
                        dct_cs_r    <= 1'b0;
                        idx_r       <= '0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= cap_s[0];
                        out_idx_r   <= '0;
                        out_last_r  <= 1'b0;
                        state_r     <= S_DRAIN;
                    end else begin
                        wcnt_r <= wcnt_r + WCNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // out_valid is always high here, so out_ready alone is the handshake.
                    if (out_ready) begin
                        if (idx_r == IDX_W'(N_PTS - 1)) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= '0;
                            out_idx_r   <= '0;
                            frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
                            busy_r      <= 1'b0;
                            state_r     <= S_IDLE;
                        end else begin
                            idx_r      <= idx_r + IDX_W'(1);
                            out_idx_r  <= idx_r + IDX_W'(1);
                            out_data_r <= coef_r[idx_r + IDX_W'(1)];
                            out_last_r <= ((idx_r + IDX_W'(1)) == IDX_W'(N_PTS - 1));
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign dct_in    = dct_in_r;
    assign dct_en    = dct_en_r;
    assign dct_cs    = dct_cs_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_dct_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dct_frame_ctrl
// Directed bench for dct_frame_ctrl. The DCT is modelled as a DCT_LAT-stage
// pipeline over an integer cosine reference (64*cos, rounded). Frame counter
// is instantiated 4 bits wide so wrap-around is reachable.
// -----------------------------------------------------------------------------
module tb_dct_frame_ctrl;
    import dct_pkg::*;

    localparam int DIN_W   = 8;
    localparam int DOUT_W  = 19;
    localparam int DCT_LAT = 2;
    localparam int FCNT_W  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic [DIN_W-1:0]      in_data = '0;
    logic                  in_ready;
    logic [8*DIN_W-1:0]    dct_in;
    logic                  dct_en;
    logic                  dct_cs;
    logic [8*DOUT_W-1:0]   dct_z;
    logic [DOUT_W-2:0]     thresh = '0;
    logic                  out_valid;
    logic [DOUT_W-1:0]     out_data;
    logic [2:0]            out_idx;
    logic                  out_last;
    logic                  out_ready = 1'b1;
    logic                  busy;
    logic [FCNT_W-1:0]     frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dct_frame_ctrl #(
        .DIN_W     (DIN_W),
        .DOUT_W    (DOUT_W),
        .DCT_LAT   (DCT_LAT),
        .FCNT_W    (FCNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dct_in    (dct_in),
        .dct_en    (dct_en),
        .dct_cs    (dct_cs),
        .dct_z     (dct_z),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // ---------------- reference DCT ----------------
    function automatic int ctab(input int i);
        case (i)
            0: return 64;
            1: return 63;
            2: return 59;
            3: return 53;
            4: return 45;
            5: return 36;
            6: return 24;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int cosv(input int m);
        int r;
        r = m % 32;
        if (r <= 8) return ctab(r);
        else if (r <= 16) return -ctab(16 - r);
        else if (r <= 24) return -ctab(r - 16);
        else return ctab(32 - r);
    endfunction

    function automatic int ref_coef(input logic [63:0] fr, input int k);
        int acc;
        logic signed [7:0] s;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            s = fr[n*8 +: 8];
            acc = acc + int'(s) * cosv((2*n + 1) * k);
        end
        return acc;
    endfunction

    function automatic logic [63:0] mk_frame(input int f);
        logic [63:0] fr;
        for (int n = 0; n < 8; n++) begin
            fr[n*8 +: 8] = 8'(f*5 + n*3 - 20);
        end
        return fr;
    endfunction

    logic                     force_z = 1'b0;
    logic signed [DOUT_W-1:0] force_vec [8];
    logic signed [DOUT_W-1:0] pipe1 [8];
    logic signed [DOUT_W-1:0] pipe2 [8];

    // DCT model: result appears DCT_LAT cycles after the dct_en cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (dct_en) pipe1[k] <= force_z ? force_vec[k] : 19'(ref_coef(dct_in, k));
            pipe2[k] <= pipe1[k];
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_z
        assign dct_z[g*DOUT_W +: DOUT_W] = pipe2[g];
    end

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [2:0]               idx;
        logic signed [DOUT_W-1:0] data;
        logic                     last;
    } beat_t;

    beat_t       q[$];
    int          cyc = 0;
    int          en_cyc = 0;
    int          last_cyc = 0;
    int          en_cnt = 0;
    int          dct_in_err = 0;
    logic [63:0] en_in = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q.push_back(beat_t'({out_idx, out_data, out_last}));
                if (out_last) last_cyc <= cyc;
            end
            if (dct_en) begin
                en_cyc <= cyc;
                en_cnt <= en_cnt + 1;
                en_in  <= dct_in;
            end
            if (dct_cs && !dct_en && dct_in != en_in) dct_in_err <= dct_in_err + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_sample(input logic [7:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] fr);
        for (int n = 0; n < 8; n++) send_sample(fr[n*8 +: 8]);
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        if (q.size() < n) check("beat_timeout", q.size(), n);
    endtask

    task automatic check_frame(input int base, input logic [63:0] fr);
        for (int k = 0; k < 8; k++) begin
            if (q.size() > base + k) begin
                check($sformatf("coef%0d", k), longint'(q[base+k].data), ref_coef(fr, k));
                check($sformatf("idx%0d", k), q[base+k].idx, k);
                check($sformatf("last%0d", k), q[base+k].last, (k == 7) ? 1 : 0);
            end
        end
    endtask

    logic [63:0] fr_a = 64'h0807060504030201;
    logic [63:0] fr_b = 64'h807FFF0032CE649C;
    logic [63:0] fr_c = 64'h11F022E033D044C0;
    logic [63:0] fr_d = 64'h0102030405060708;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int b_last;
        int seen;
        logic signed [DOUT_W-1:0] exp_v [8];

        // ---- 1: reset state, basic frame, latency ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_dct_in", dct_in, 0);
        check("rst_dct_en", dct_en, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(fr_a);
        @(negedge clk) check("lat_en_e0", dct_en, 0);
        @(negedge clk) check("lat_en_e1", dct_en, 0);
        @(negedge clk);
        check("lat_en_e2", dct_en, 1);
        check("lat_cs_l", dct_cs, 1);
        check("lat_busy", busy, 1);
        check("dct_in_a", dct_in, 64'h0807060504030201);
        @(negedge clk);
        check("en_pulse", dct_en, 0);
        check("cs_l1", dct_cs, 1);
        @(negedge clk);
        check("cs_l2", dct_cs, 1);
        check("valid_early", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("cs_off", dct_cs, 0);
        check("first_idx", out_idx, 0);
        #1;
        wait_beats(8);
        check("a_beats", q.size(), 8);
        check_frame(0, fr_a);
        @(posedge clk); #1;
        check("frame_cnt_1", frame_cnt, 1);
        check("en_cnt_1", en_cnt, 1);

        // ---- 2/3: stall at idx 3, next frame filled during drain ----
        q.delete();
        send_frame(fr_b);
        t = 0;
        while (!(out_valid && out_idx == 3'd2) && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("reach_idx2", out_idx, 2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send_frame(fr_c);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("hold_idx", out_idx, 3);
                    check("hold_data", longint'($signed(out_data)), ref_coef(fr_b, 3));
                    check("hold_valid", out_valid, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("c_full_ready", in_ready, 0);
        check("c_no_launch", en_cnt, 2);
        wait_beats(8);
        b_last = last_cyc;
        wait_beats(16);
        check("bc_beats", q.size(), 16);
        check_frame(0, fr_b);
        check_frame(8, fr_c);
        check("c_en_after_last", en_cyc - b_last, 2);
        check("dct_in_stable", dct_in_err, 0);
        check("en_cnt_3", en_cnt, 3);
        @(posedge clk); #1;
        check("frame_cnt_3", frame_cnt, 3);

        // ---- 4: asynchronous reset in S_WAIT cycle L+1 ----
        q.delete();
        send_frame(fr_d);
        t = 0;
        while (!dct_en && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("d_launch", dct_en, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_cs", dct_cs, 0);
        check("arst_en", dct_en, 0);
        check("arst_busy", busy, 0);
        check("arst_dct_in", dct_in, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_valid_after_rst", seen, 0);
        @(posedge clk); #1;

        // ---- 5: threshold vector ----
        q.delete();
        thresh = 18'd10;
        force_vec[0] = 19'sd9;
        force_vec[1] = -19'sd9;
        force_vec[2] = 19'sd10;
        force_vec[3] = -19'sd10;
        force_vec[4] = 19'sd0;
        force_vec[5] = -19'sd262144;
        force_vec[6] = 19'sd262143;
        force_vec[7] = 19'sd11;
`ifdef DCT_CTRL_THRESH_EN
        exp_v[0] = 19'sd0;
        exp_v[1] = 19'sd0;
`else
        exp_v[0] = 19'sd9;
        exp_v[1] = -19'sd9;
`endif
        exp_v[2] = 19'sd10;
        exp_v[3] = -19'sd10;
        exp_v[4] = 19'sd0;
        exp_v[5] = -19'sd262144;
        exp_v[6] = 19'sd262143;
        exp_v[7] = 19'sd11;
        force_z = 1'b1;
        send_frame(fr_a);
        wait_beats(8);
        for (int k = 0; k < 8; k++) begin
            if (q.size() > k) check($sformatf("thr%0d", k), longint'(q[k].data), longint'(exp_v[k]));
        end
        @(posedge clk); #1;
        force_z = 1'b0;

        // ---- 6: frame counter wrap ----
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        q.delete();
        check("wrap_start", frame_cnt, 0);
        for (int f = 0; f < 16; f++) send_frame(mk_frame(f));
        wait_beats(128);
        @(posedge clk); #1;
        check("wrap_zero", frame_cnt, 0);
        check_frame(120, mk_frame(15));
        send_frame(fr_b);
        wait_beats(136);
        check_frame(128, fr_b);
        @(posedge clk); #1;
        check("wrap_one", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
